// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the CP0 exception sequencer: ExcCode values, NPC select
// encodings, sequencer state and the oldest-fault merge rule.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [1:0] NPC_NORMAL  = 2'd0;
  localparam logic [1:0] NPC_HANDLER = 2'd1;
  localparam logic [1:0] NPC_EPC     = 2'd2;

  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } exc_state_e;

  // A code already carried by an instruction came from an earlier stage, so it wins.
  function automatic logic [4:0] oldestExc(input logic [4:0] carried,
                                           input logic [4:0] detected);
    return (carried != EXC_INT) ? carried : detected;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_stage_slot.sv
// One pipeline slot of exception state (pc/bd/exc) with hold, bubble insertion,
// oldest-fault merge and flush-clear.
module exc_stage_slot
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic        bd_i,
  input  logic [4:0]  exc_old_i,
  input  logic [4:0]  exc_new_i,
  output logic [31:0] pc_o,
  output logic        bd_o,
  output logic [4:0]  exc_o
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;

  // Clear beats hold: a flush must empty the slot even while stalled.
  always_comb begin
    pc_d  = pc_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    if (clear_i) begin
      pc_d  = HANDLER_PC;
      bd_d  = 1'b0;
      exc_d = EXC_INT;
    end else if (!hold_i) begin
      pc_d  = pc_i;
      bd_d  = bd_i;
      exc_d = bubble_i ? EXC_INT : oldestExc(exc_old_i, exc_new_i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      bd_q  <= 1'b0;
      exc_q <= EXC_INT;
    end else begin
      pc_q  <= pc_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
    end
  end

  assign pc_o  = pc_q;
  assign bd_o  = bd_q;
  assign exc_o = exc_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt sequencer: carries the oldest fault from F to M, presents it
// to CP0, and turns IntReq / eret into EXL control, a flush and an NPC redirect.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc_f,
  input  logic        bd_f,
  input  logic [4:0]  exc_f,
  input  logic [4:0]  exc_d,
  input  logic [4:0]  exc_e,
  input  logic [4:0]  exc_m,
  input  logic        eret_m,
  input  logic        int_req,
  output logic [31:0] cp0_pc,
  output logic        cp0_bd,
  output logic [4:0]  cp0_exc,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        flush,
  output logic [1:0]  npc_sel
);

  exc_state_e state_q, state_d;

  logic        excEn;
  logic        takeTrap, takeEret;
  logic [4:0]  excF, excD, excE, excM;
  logic [31:0] dPc, ePc, mPc;
  logic        dBd, eBd, mBd;
  logic [4:0]  dExc, eExc, mExc;

  // Stage faults and eret only count in RUN; reset also silences the trap port.
  assign excEn    = reset && (state_q == RUN);
  assign excF     = excEn ? exc_f : EXC_INT;
  assign excD     = excEn ? exc_d : EXC_INT;
  assign excE     = excEn ? exc_e : EXC_INT;
  assign excM     = excEn ? exc_m : EXC_INT;
  assign takeTrap = excEn && int_req;
  assign takeEret = excEn && eret_m && !int_req;

  always_comb begin
    state_d = state_q;
    exl_set = 1'b0;
    exl_clr = 1'b0;
    flush   = 1'b0;
    npc_sel = NPC_NORMAL;
    case (state_q)
      RUN: begin
        if (takeTrap) begin
          exl_set = 1'b1;
          flush   = 1'b1;
          npc_sel = NPC_HANDLER;
          state_d = TRAP;
        end else if (takeEret) begin
          exl_clr = 1'b1;
          flush   = 1'b1;
          npc_sel = NPC_EPC;
          state_d = TRAP;
        end
      end
      TRAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  exc_stage_slot #(.RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC)) u_slot_d (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (flush),
    .hold_i    (stall),
    .bubble_i  (1'b0),
    .pc_i      (pc_f),
    .bd_i      (bd_f),
    .exc_old_i (EXC_INT),
    .exc_new_i (excF),
    .pc_o      (dPc),
    .bd_o      (dBd),
    .exc_o     (dExc)
  );

  // A stalled D slot feeds E a bubble that still carries its pc/bd for EPC.
  exc_stage_slot #(.RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC)) u_slot_e (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (flush),
    .hold_i    (1'b0),
    .bubble_i  (stall),
    .pc_i      (dPc),
    .bd_i      (dBd),
    .exc_old_i (dExc),
    .exc_new_i (excD),
    .pc_o      (ePc),
    .bd_o      (eBd),
    .exc_o     (eExc)
  );

  exc_stage_slot #(.RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC)) u_slot_m (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (flush),
    .hold_i    (1'b0),
    .bubble_i  (1'b0),
    .pc_i      (ePc),
    .bd_i      (eBd),
    .exc_old_i (eExc),
    .exc_new_i (excE),
    .pc_o      (mPc),
    .bd_o      (mBd),
    .exc_o     (mExc)
  );

  assign cp0_pc  = mPc;
  assign cp0_bd  = mBd;
  assign cp0_exc = oldestExc(mExc, excM);

endmodule
